// File: rtl/pc_pkg.sv
// Shared command/state encodings and the command priority helper for pc_seq4.
package pc_pkg;

    typedef logic [1:0] cmd_t;
    localparam cmd_t CMD_NONE = 2'd0;
    localparam cmd_t CMD_INC  = 2'd1;
    localparam cmd_t CMD_LOAD = 2'd2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_STALL = 2'd2;

    // load wins over inc when both are requested in the same cycle
    function automatic cmd_t encode_cmd(input logic load, input logic inc);
        if (load)     return CMD_LOAD;
        else if (inc) return CMD_INC;
        else          return CMD_NONE;
    endfunction

    function automatic cmd_t pick_cmd(input cmd_t cur, input cmd_t pend);
        if (cur == CMD_LOAD)       return CMD_LOAD;
        else if (pend == CMD_LOAD) return CMD_LOAD;
        else if (cur == CMD_INC)   return CMD_INC;
        else if (pend == CMD_INC)  return CMD_INC;
        else                       return CMD_NONE;
    endfunction

endpackage

// File: rtl/pc_seq4_if.sv
// Command/handshake bundle between the upstream sequencer and pc_seq4.
// The wrap flag exists only when PC_WRAP_FLAG_EN is defined.
interface pc_seq4_if #(parameter int WIDTH = 4);
    logic             load;
    logic [WIDTH-1:0] in;
    logic             inc;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] out;
`ifdef PC_WRAP_FLAG_EN
    logic             wrap;
`endif

    modport master (
        output load, in, inc, ready,
`ifdef PC_WRAP_FLAG_EN
        input  wrap,
`endif
        input  valid, out
    );

    modport slave (
        input  load, in, inc, ready,
`ifdef PC_WRAP_FLAG_EN
        output wrap,
`endif
        output valid, out
    );
endinterface

// File: rtl/pc_cmd_buf.sv
// One-entry pending command register: a load overwrites anything, an inc never
// displaces a pending load, and clear empties the entry.
module pc_cmd_buf
    import pc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  cmd_t             cmd,
    input  logic [WIDTH-1:0] tgt,
    input  logic             clear,
    output cmd_t             pend_kind,
    output logic [WIDTH-1:0] pend_tgt
);

    cmd_t             kind_q, kind_d;
    logic [WIDTH-1:0] tgt_q,  tgt_d;

    always_comb begin
        // NOTE: defaults first so every path assigns the _d signals and no latch is inferred.
        kind_d = kind_q;
        tgt_d  = tgt_q;
        if (clear) begin
            kind_d = CMD_NONE;
        end else if (wr_en) begin
            if (cmd == CMD_LOAD) begin
                kind_d = CMD_LOAD;
                tgt_d  = tgt;
            end else if (cmd == CMD_INC && kind_q != CMD_LOAD) begin
                kind_d = CMD_INC;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q <= CMD_NONE;
            tgt_q  <= '0;
        end else begin
            kind_q <= kind_d;
            tgt_q  <= tgt_d;
        end
    end

    assign pend_kind = kind_q;
    assign pend_tgt  = tgt_q;

endmodule

// File: rtl/pc_seq4.sv
// 4-bit program counter with valid/ready presentation and a one-entry command buffer.
// Optional one-cycle wrap pulse on increment overflow when PC_WRAP_FLAG_EN is defined.
module pc_seq4
    import pc_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    pc_seq4_if.slave     bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q,   out_d;
    cmd_t             cur_cmd, eff_cmd, pend_kind;
    logic [WIDTH-1:0] pend_tgt;
    logic             apply;

    assign cur_cmd = encode_cmd(bus.load, bus.inc);
    assign apply   = (state_q != ST_IDLE) && bus.ready;
    assign eff_cmd = pick_cmd(cur_cmd, pend_kind);

    // commands arriving on any cycle without an update are parked in the buffer
    pc_cmd_buf #(.WIDTH(WIDTH)) u_cmd_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (!apply),
        .cmd       (cur_cmd),
        .tgt       (bus.in),
        .clear     (apply),
        .pend_kind (pend_kind),
        .pend_tgt  (pend_tgt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = bus.ready ? ST_RUN : ST_STALL;
            ST_STALL: state_d = bus.ready ? ST_RUN : ST_STALL;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        if (apply) begin
            case (eff_cmd)
                CMD_LOAD: out_d = (cur_cmd == CMD_LOAD) ? bus.in : pend_tgt;
                CMD_INC:  out_d = out_q + 1'b1;
                default:  out_d = out_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= RST_VAL;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign bus.valid = (state_q != ST_IDLE);
    assign bus.out   = out_q;

`ifdef PC_WRAP_FLAG_EN
    logic wrap_q, wrap_d;

    assign wrap_d = apply && (eff_cmd == CMD_INC) && (out_q == {WIDTH{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap_q <= 1'b0;
        else     wrap_q <= wrap_d;
    end

    assign bus.wrap = wrap_q;
`endif

endmodule

// File: tb/tb_pc_seq4.sv
// Directed bench for pc_seq4 with a behavioural Mux4 feeding the load target.
module tb_pc_seq4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [3:0] mux_a, mux_b;
    int         vectors     = 0;
    int         miscompares = 0;

    pc_seq4_if #(.WIDTH(4)) bus ();

    pc_seq4 #(.WIDTH(4), .RST_VAL(4'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Mux4 upstream: sel=1 picks the branch address, sel=0 the external value
    assign bus.in = sel ? mux_b : mux_a;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.inc   = 1'b0;
        bus.ready = 1'b0;
        sel       = 1'b0;
        mux_a     = 4'h0;
        mux_b     = 4'h0;
        #1;
        check("async_reset_out", {4'h0, bus.out}, 8'h00);
        check("async_reset_valid", {7'h0, bus.valid}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset then run: IDLE first, then counting 0,1,2,... with wrap after 16
        bus.inc   = 1'b1;
        bus.ready = 1'b1;
        check("idle_valid", {7'h0, bus.valid}, 8'h00);
        check("idle_out", {4'h0, bus.out}, 8'h00);
        step();
        check("run_valid", {7'h0, bus.valid}, 8'h01);
        check("run_out0", {4'h0, bus.out}, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("inc_%0d", i), {4'h0, bus.out}, {4'h0, 4'(i)});
`ifdef PC_WRAP_FLAG_EN
            check($sformatf("wrap_%0d", i), {7'h0, bus.wrap}, (i == 16) ? 8'h01 : 8'h00);
`endif
        end

        // load via Mux4 branch input, then increment
        bus.inc  = 1'b0;
        bus.load = 1'b1;
        sel      = 1'b1;
        mux_b    = 4'hA;
        mux_a    = 4'h3;
        step();
        check("load_A", {4'h0, bus.out}, 8'h0A);
        bus.load = 1'b0;
        bus.inc  = 1'b1;
        step();
        check("inc_after_load", {4'h0, bus.out}, 8'h0B);

        // stall buffering: pending load survives a later inc
        bus.inc  = 1'b0;
        bus.load = 1'b1;
        sel      = 1'b0;
        step();
        check("load_3", {4'h0, bus.out}, 8'h03);
        bus.ready = 1'b0;
        sel       = 1'b1;
        mux_b     = 4'h9;
        step();
        check("stall_hold_a", {4'h0, bus.out}, 8'h03);
        check("stall_valid_a", {7'h0, bus.valid}, 8'h01);
        mux_b    = 4'hF;
        bus.load = 1'b0;
        bus.inc  = 1'b1;
        step();
        check("stall_hold_b", {4'h0, bus.out}, 8'h03);
        check("stall_valid_b", {7'h0, bus.valid}, 8'h01);
        bus.inc   = 1'b0;
        bus.ready = 1'b1;
        step();
        check("release_pending_load", {4'h0, bus.out}, 8'h09);
        check("release_valid", {7'h0, bus.valid}, 8'h01);

        // priority on release: current load beats pending inc, pending then cleared
        bus.ready = 1'b0;
        bus.inc   = 1'b1;
        step();
        check("stall_pend_inc", {4'h0, bus.out}, 8'h09);
        bus.inc   = 1'b0;
        bus.load  = 1'b1;
        mux_b     = 4'h5;
        bus.ready = 1'b1;
        step();
        check("cur_load_wins", {4'h0, bus.out}, 8'h05);
        bus.load = 1'b0;
        step();
        check("pending_cleared", {4'h0, bus.out}, 8'h05);

        // simultaneous load+inc acts as load
        bus.load = 1'b1;
        mux_b    = 4'h7;
        step();
        check("load_7", {4'h0, bus.out}, 8'h07);
        bus.inc = 1'b1;
        mux_b   = 4'h2;
        step();
        check("load_and_inc", {4'h0, bus.out}, 8'h02);
        bus.load = 1'b0;
        bus.inc  = 1'b0;

        // reset mid-stall discards the pending load
        bus.ready = 1'b0;
        step();
        check("pre_rst_stall", {4'h0, bus.out}, 8'h02);
        bus.load = 1'b1;
        mux_b    = 4'hC;
        step();
        check("pre_rst_pend", {4'h0, bus.out}, 8'h02);
        bus.load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out", {4'h0, bus.out}, 8'h00);
        check("mid_rst_valid", {7'h0, bus.valid}, 8'h00);
        step();
        rst = 1'b0;
        bus.ready = 1'b1;
        check("post_rst_idle", {7'h0, bus.valid}, 8'h00);
        step();
        check("post_rst_run_valid", {7'h0, bus.valid}, 8'h01);
        check("post_rst_out_a", {4'h0, bus.out}, 8'h00);
        step();
        check("post_rst_no_load", {4'h0, bus.out}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_seq4.md
Name: pc_seq4

Overview:
- 4-bit program-counter stage that consumes the Mux4 output as its jump/load target.
- Mux4 selects between a branch address and an external value; pc_seq4 registers it on load, or increments its own count.
- The count is presented to the downstream fetch/ROM stage through a valid/ready handshake.
- A one-entry command buffer keeps load/inc requests issued while downstream stalls from being lost.

Parameters:
WIDTH, 4, counter and load-target width in bits
RST_VAL, 0, counter value after reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
load  input  1  load request; target on `in`
in  input  WIDTH  load target (driven by Mux4 out)
inc  input  1  increment request
ready  input  1  downstream accepts current out this cycle
valid  output  1  out holds a presentable count
out  output  WIDTH  current program counter

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - out=RST_VAL, valid=0, pending buffer empty, state=IDLE.
- States:
  - IDLE: valid=0; next cycle always goes to RUN. Load/inc in this cycle are captured into pending.
  - RUN: valid=1. On a cycle with ready=1 an update is applied (next bullet). With ready=0 the next state is STALL; out is held.
  - STALL: valid=1; out is held. Commands go to pending. When ready=1, apply the update and return to RUN.
- Update (ready=1 in RUN/STALL, registered; visible next cycle, latency 1):
  - Effective command priority: current load > pending load > current inc > pending inc > none.
  - load: out<=in (the current `in`, or the stored target for a pending load).
  - inc: out<=out+1, modulo 2^WIDTH. 4'hF wraps to 4'h0 with no error.
  - Exactly one action per update; lower-priority requests that cycle are discarded. Pending is cleared.
- Pending buffer (one entry: kind + WIDTH-bit target), written on any cycle where no update is applied:
  - New load overwrites any pending entry, including an older load.
  - New inc is written only if pending is empty or holds an inc. It never displaces a pending load.
  - load=1 and inc=1 together are treated as load.
- Reset mid-stall: pending is discarded, out=RST_VAL, state returns to IDLE.
- valid never drops between RUN and STALL. It drops only on reset.
- `in` is sampled only when a load is registered (into pending) or applied, so Mux4 may change it freely on other cycles.

Optional Feature:
- PC_WRAP_FLAG_EN defined:
  - Adds output port wrap (1 bit, reset 0).
  - wrap pulses high for exactly one cycle, the cycle after an applied inc takes out from 2^WIDTH-1 to 0.
  - A load of 0 does not set it.
- Undefined: the port and its logic are absent. Counting behaviour is identical.

Decomposition:
- Shared package pc_pkg:
  - Command encoding CMD_NONE=2'd0, CMD_INC=2'd1, CMD_LOAD=2'd2.
  - State encoding ST_IDLE, ST_RUN, ST_STALL.
  - Priority helper function pick_cmd(cur, pend) returning the effective command.
- Sub-module pc_cmd_buf: one-entry pending register with the overwrite rules above. It exposes pend_kind/pend_tgt and clear.
- The top holds the FSM, counter and handshake.

Test Plan:
- Reset then run: rst=1 for 2 cycles, release, inc=1 with ready=1 held → valid=0 first cycle, then out 0,1,2,3…; after 16 incs out=4'h0 (and wrap pulses once if PC_WRAP_FLAG_EN).
- Load via Mux4: sel=1, b=4'hA, load=1 one cycle, ready=1 → out=4'hA next cycle; following inc → 4'hB.
- Stall buffering: out=3, ready=0, load=1 in=4'h9, then inc=1 next cycle, then ready=1 with no command → out holds 3 through stall, becomes 9 (inc discarded), valid stays 1.
- Priority on release: pending inc, then ready=1 with load=1 in=4'h5 → out=5, pending cleared, next idle cycle out stays 5.
- Simultaneous load+inc: out=7, load=1 inc=1 in=4'h2 ready=1 → out=2.
- Reset mid-stall: pending load 4'hC, ready=0, assert rst asynchronously mid-cycle → out=0 and valid=0 immediately; after release the pending load is not applied.
